// File: rtl/fpcvt_pkg.sv
`default_nettype none
// ============================================================================
// | Module      : fpcvt_pkg                                                  |
// | Description : Shared constants for the FPCVT converter and the state     |
// |               encoding of its serial word loader.                        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
// Contents:
//   FPCVT_D_W / FPCVT_E_W / FPCVT_F_W : converter input word, exponent and
//                                       fraction widths
//   ldr_state_e                       : loader FSM states
package fpcvt_pkg;

   localparam int FPCVT_D_W = 12;
   localparam int FPCVT_E_W = 3;
   localparam int FPCVT_F_W = 4;

   typedef enum logic [1:0] {
      LDR_IDLE  = 2'd0,
      LDR_SHIFT = 2'd1,
      LDR_HOLD  = 2'd2
   } ldr_state_e;

endpackage
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// | Module      : sipo_shift_reg                                             |
// | Description : Serial-in parallel-out shift register with a synchronous   |
// |               clear that can coincide with a shift.                      |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset (register -> 0)
//   clr    in   1      zero the register before this cycle's shift
//   en     in   1      shift din in this cycle
//   din    in   1      serial data bit
//   q      out  WIDTH  current register contents
//   q_nxt  out  WIDTH  value the register takes on the next edge
module sipo_shift_reg #(
   parameter int WIDTH     = 12,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] shifted;

   // Clear is applied before the shift so that a restart strobe carrying a
   // bit lands that bit as the first bit of the fresh frame.
   assign base = clr ? '0 : sr_q;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {base[WIDTH-2:0], din};
      end else begin : g_lsb_first
         assign shifted = {din, base[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      sr_d = base;
      if (en) begin
         sr_d = shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign q     = sr_q;
   assign q_nxt = sr_d;

endmodule
`default_nettype wire

// File: rtl/fpcvt_word_loader.sv
`default_nettype none
// ============================================================================
// | Module      : fpcvt_word_loader                                          |
// | Description : Serial-to-parallel front end for FPCVT. Assembles a        |
// |               WIDTH-bit word one bit per strobe and holds it stable on   |
// |               d_out under a valid/ready handshake.                       |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset, highest priority
//   start      in   1      begin a new frame (discards any partial word)
//   bit_in     in   1      serial data bit, sampled when bit_valid=1
//   bit_valid  in   1      bit strobe
//   d_out      out  WIDTH  assembled word, wired to FPCVT.D
//   d_valid    out  1      d_out holds a complete word (HOLD state)
//   d_ready    in   1      consumer accepts when d_valid & d_ready
//   busy       out  1      frame in progress (SHIFT state)
//   overrun    out  1      sticky: a bit strobe arrived while holding a word
//   word_cnt   out  CNT_W  accepted-word count, wraps
module fpcvt_word_loader
   import fpcvt_pkg::*;
#(
   parameter int WIDTH     = FPCVT_D_W,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int            BC_W     = $clog2(WIDTH);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);

   ldr_state_e       state_q, state_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] d_out_q, d_out_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   logic             sr_clr;
   logic             sr_en;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_nxt;

   // A restart strobe counts as bit 0 when it carries a bit.
   logic [BC_W-1:0]  restart_cnt;
   assign restart_cnt = {{(BC_W-1){1'b0}}, bit_valid};

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sipo (
      .clk   (clk),
      .rst   (rst),
      .clr   (sr_clr),
      .en    (sr_en),
      .din   (bit_in),
      .q     (sr_q),
      .q_nxt (sr_nxt)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      d_out_d    = d_out_q;
      overrun_d  = overrun_q;
      word_cnt_d = word_cnt_q;
      sr_clr     = 1'b0;
      sr_en      = 1'b0;

      unique case (state_q)
         LDR_IDLE: begin
            // Strobes while idle are dropped silently.
            if (start) begin
               state_d   = LDR_SHIFT;
               bit_cnt_d = '0;
               sr_clr    = 1'b1;
            end
         end

         LDR_SHIFT: begin
            if (start) begin
               sr_clr    = 1'b1;
               sr_en     = bit_valid;
               bit_cnt_d = restart_cnt;
            end else if (bit_valid) begin
               sr_en = 1'b1;
               if (bit_cnt_q == BC_LAST) begin
                  // Completed word goes straight to the output register;
                  // d_out never shows a partially shifted word.
                  state_d   = LDR_HOLD;
                  d_out_d   = sr_nxt;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         LDR_HOLD: begin
            if (d_ready) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (start) begin
                  state_d   = LDR_SHIFT;
                  sr_clr    = 1'b1;
                  sr_en     = bit_valid;
                  bit_cnt_d = restart_cnt;
               end else begin
                  state_d = LDR_IDLE;
               end
            end
            // A strobe consumed as bit 0 of an immediate restart is not lost.
            if (bit_valid && !(start && d_ready)) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = LDR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LDR_IDLE;
         bit_cnt_q  <= '0;
         d_out_q    <= '0;
         overrun_q  <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         d_out_q    <= d_out_d;
         overrun_q  <= overrun_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // sr_q is only observed through sr_nxt; keep it visibly consumed.
   logic unused_sr;
   assign unused_sr = ^sr_q;

   assign d_out    = d_out_q;
   assign d_valid  = (state_q == LDR_HOLD);
   assign busy     = (state_q == LDR_SHIFT);
   assign overrun  = overrun_q;
   assign word_cnt = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_word_loader.sv
`default_nettype none
// ============================================================================
// | Module      : tb_fpcvt_word_loader                                       |
// | Description : Self-checking bench for fpcvt_word_loader. Two instances   |
// |               see the same bit stream, one MSB-first and one LSB-first.  |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_fpcvt_word_loader;

   localparam int W = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          bit_in;
   logic          bit_valid;
   logic          d_ready;

   logic [W-1:0]  d_out_m, d_out_l;
   logic          d_valid_m, d_valid_l;
   logic          busy_m, busy_l;
   logic          overrun_m, overrun_l;
   logic [7:0]    word_cnt_m, word_cnt_l;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   fpcvt_word_loader #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(8)) dut_m (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .d_out(d_out_m), .d_valid(d_valid_m), .d_ready(d_ready), .busy(busy_m),
      .overrun(overrun_m), .word_cnt(word_cnt_m)
   );

   fpcvt_word_loader #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(8)) dut_l (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .d_out(d_out_l), .d_valid(d_valid_l), .d_ready(d_ready), .busy(busy_l),
      .overrun(overrun_l), .word_cnt(word_cnt_l)
   );

   typedef struct {
      logic [W-1:0] word;   // bits sent word[11] first
      int           gap;    // idle cycles before each strobe
      logic [W-1:0] exp_m;  // expected MSB-first result
      logic [W-1:0] exp_l;  // expected LSB-first result (bit reversal)
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int hi, input int lo, input int gap);
      for (int i = hi; i >= lo; i--) begin
         for (int g = 0; g < gap; g++) tick();
         bit_in    = w[i];
         bit_valid = 1'b1;
         tick();
         bit_valid = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [W-1:0] w, input int gap);
      pulse_start();
      send_bits(w, W-1, 0, gap);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      vecs[0] = '{12'h7FF, 0, 12'h7FF, 12'hFFE};
      vecs[1] = '{12'h800, 1, 12'h800, 12'h001};
      vecs[2] = '{12'h0AD, 2, 12'h0AD, 12'hB50};
      vecs[3] = '{12'hFFE, 3, 12'hFFE, 12'h7FF};
      vecs[4] = '{12'h000, 0, 12'h000, 12'h000};
      vecs[5] = '{12'hA5C, 1, 12'hA5C, 12'h3A5};

      rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; d_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_d_out",    {20'd0, d_out_m}, 32'h0);
      check("rst_d_valid",  {31'd0, d_valid_m}, 32'h0);
      check("rst_busy",     {31'd0, busy_m}, 32'h0);
      check("rst_overrun",  {31'd0, overrun_m}, 32'h0);
      check("rst_word_cnt", {24'd0, word_cnt_m}, 32'h0);

      // 7FF with d_ready held high: valid for exactly one cycle
      d_ready = 1'b1;
      pulse_start();
      check("t1_busy", {31'd0, busy_m}, 32'h1);
      send_bits(12'h7FF, W-1, 0, 0);
      check("t1_d_out",   {20'd0, d_out_m}, 32'h7FF);
      check("t1_d_valid", {31'd0, d_valid_m}, 32'h1);
      check("t1_busy_hold", {31'd0, busy_m}, 32'h0);
      tick();
      exp_cnt = 1;
      check("t1_d_valid_drop", {31'd0, d_valid_m}, 32'h0);
      check("t1_word_cnt", {24'd0, word_cnt_m}, 32'd1);
      check("t1_d_out_kept", {20'd0, d_out_m}, 32'h7FF);
      d_ready = 1'b0;

      // Table-driven words, both bit orders, varied strobe gaps
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].word, vecs[v].gap);
         check("vec_d_valid", {31'd0, d_valid_m & d_valid_l}, 32'h1);
         check("vec_busy",    {31'd0, busy_m | busy_l}, 32'h0);
         check("vec_d_out_m", {20'd0, d_out_m}, {20'd0, vecs[v].exp_m});
         check("vec_d_out_l", {20'd0, d_out_l}, {20'd0, vecs[v].exp_l});
         d_ready = 1'b1;
         tick();
         d_ready = 1'b0;
         exp_cnt = (exp_cnt + 1) % 256;
         check("vec_accept", {31'd0, d_valid_m}, 32'h0);
         check("vec_word_cnt", {24'd0, word_cnt_m}, exp_cnt);
         check("vec_word_cnt_l", {24'd0, word_cnt_l}, exp_cnt);
      end

      // 800 held while d_ready low for 20 cycles
      send_frame(12'h800, 0);
      for (int c = 0; c < 20; c++) begin
         check("t2_hold_d_out", {20'd0, d_out_m}, 32'h800);
         check("t2_hold_valid", {31'd0, d_valid_m}, 32'h1);
         tick();
      end
      check("t2_cnt_unchanged", {24'd0, word_cnt_m}, exp_cnt);

      // Overrun while holding, then start without handshake is ignored
      bit_in = 1'b1;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      check("t3_overrun",   {31'd0, overrun_m}, 32'h1);
      check("t3_d_out",     {20'd0, d_out_m}, 32'h800);
      check("t3_d_valid",   {31'd0, d_valid_m}, 32'h1);
      pulse_start();
      check("t3_start_ign_valid", {31'd0, d_valid_m}, 32'h1);
      check("t3_start_ign_busy",  {31'd0, busy_m}, 32'h0);
      check("t3_overrun_sticky",  {31'd0, overrun_m}, 32'h1);
      do_reset();
      check("t3_rst_overrun", {31'd0, overrun_m}, 32'h0);
      check("t3_rst_d_out",   {20'd0, d_out_m}, 32'h0);
      check("t3_rst_valid",   {31'd0, d_valid_m}, 32'h0);
      check("t3_rst_cnt",     {24'd0, word_cnt_m}, 32'h0);

      // Partial frame abandoned by a new start
      pulse_start();
      send_bits(12'hFFF, W-1, W-5, 0);
      check("t4_partial_no_valid", {31'd0, d_valid_m}, 32'h0);
      check("t4_partial_d_out",    {20'd0, d_out_m}, 32'h0);
      send_frame(12'h0AD, 0);
      check("t4_d_out_m", {20'd0, d_out_m}, 32'h0AD);
      check("t4_d_out_l", {20'd0, d_out_l}, 32'hB50);

      // Accept with d_ready, then restart in SHIFT with a coincident bit
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      exp_cnt = exp_cnt + 1;
      pulse_start();
      send_bits(12'hFFF, W-1, W-3, 0);
      start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;   // bit 11 of 12'h935
      tick();
      start = 1'b0; bit_valid = 1'b0;
      send_bits(12'h935, W-2, 0, 0);
      check("rs_d_valid", {31'd0, d_valid_m}, 32'h1);
      check("rs_d_out_m", {20'd0, d_out_m}, 32'h935);
      check("rs_d_out_l", {20'd0, d_out_l}, 32'hAC9);

      // HOLD + start + d_ready + bit: accept and carry the bit into a new frame
      d_ready = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;  // bit 11 of 12'h5A3
      tick();
      d_ready = 1'b0; start = 1'b0; bit_valid = 1'b0;
      exp_cnt = exp_cnt + 1;
      check("hr_word_cnt", {24'd0, word_cnt_m}, exp_cnt);
      check("hr_busy",     {31'd0, busy_m}, 32'h1);
      check("hr_overrun",  {31'd0, overrun_m}, 32'h0);
      check("hr_d_out_kept", {20'd0, d_out_m}, 32'h935);
      send_bits(12'h5A3, W-2, 0, 1);
      check("hr_d_out_m", {20'd0, d_out_m}, 32'h5A3);
      check("hr_d_out_l", {20'd0, d_out_l}, 32'hC5A);
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
      exp_cnt = exp_cnt + 1;

      // Strobes in IDLE are dropped without flag
      bit_in = 1'b1;
      bit_valid = 1'b1;
      tick(); tick(); tick();
      bit_valid = 1'b0;
      check("idle_busy",    {31'd0, busy_m}, 32'h0);
      check("idle_valid",   {31'd0, d_valid_m}, 32'h0);
      check("idle_overrun", {31'd0, overrun_m}, 32'h0);
      check("idle_d_out",   {20'd0, d_out_m}, 32'h5A3);
      check("idle_cnt",     {24'd0, word_cnt_m}, exp_cnt);

      // 256 deliveries wrap the 8-bit counter back to zero
      do_reset();
      d_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [W-1:0] w;
         w = W'((i * 37 + 5) % 4096);
         send_frame(w, i % 4);
         check("wrap_d_out", {20'd0, d_out_m}, {20'd0, w});
         tick();
         exp_cnt = (exp_cnt + 1) % 256;
         check("wrap_cnt", {24'd0, word_cnt_m}, exp_cnt);
      end
      check("wrap_final_zero", {24'd0, word_cnt_m}, 32'h0);
      d_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
